ringosc_fcal: RTL

Digital frequency-calibration controller for the phase-locked-loop ring oscillator. It sequences a successive-approximation search over the DAC code that sets the oscillator's regulated supply. It counts synchronized oscillator ticks over a fixed reference window and compares the count to a target. After the search it holds the code, or tracks slow drift with ±1 LSB steps. It sits in the clk domain between the PLL control logic and the supply DAC that produces the oscillator's `vreg`.

---
 rtl/ringosc_fcal.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ringosc_fcal.sv
// Ring-oscillator frequency calibration: SAR search of the supply DAC code, then hold or +/-1 LSB tracking.
// Latency: SETTLE+WIN+1 cycles per measurement; done pulses NBIT measurements after start acceptance.
// Backpressure: none; start is ignored while busy, osc_tick is counted every COUNT cycle it is high.
module ringosc_fcal #(
   parameter int NBIT   = 6,
   parameter int CNTW   = 16,
   parameter int WIN    = 1024,
   parameter int SETTLE = 64,
   parameter int TOL    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            track_en,
   input  logic [CNTW-1:0] target,
   input  logic            osc_tick,
   output logic [NBIT-1:0] code,
   output logic            busy,
   output logic            done,
   output logic            lock,
   output logic [CNTW-1:0] count
);

   localparam int BW = (NBIT > 1) ? $clog2(NBIT) : 1;
   localparam logic [NBIT-1:0]   CODE_MSB = NBIT'(1) << (NBIT - 1);
   localparam logic [NBIT-1:0]   CODE_MAX = '1;
   localparam logic [CNTW-1:0]   CNT_MAX  = '1;
   localparam logic [BW-1:0]     BIT_TOP  = BW'(NBIT - 1);
   localparam logic [31:0]       SET_LAST = 32'(SETTLE - 1);
   localparam logic [31:0]       WIN_LAST = 32'(WIN - 1);
   localparam logic signed [CNTW:0] TOLS  = (CNTW + 1)'(TOL);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_COUNT, S_DECIDE, S_HOLD, S_TRACK
   } state_t;

   state_t                 state, nstate;
   logic                   trk;        // measurement loop is tracking, not searching
   logic [BW-1:0]          bidx;       // trial bit of the SAR search
   logic [CNTW-1:0]        tgt;        // latched target
   logic [CNTW-1:0]        cnt;        // tick counter of the current window
   logic [31:0]            tmr;        // cycle timer for SETTLE and COUNT phases
   logic                   accept;
   logic signed [CNTW:0]   diff;       // cnt - tgt without wrap at either end
   logic                   in_band;
   logic [NBIT-1:0]        code_nxt;

   // start is honoured in any state where no search is running
   assign accept  = start & ~busy;
   assign diff    = $signed({1'b0, cnt}) - $signed({1'b0, tgt});
   assign in_band = (diff <= TOLS) && (diff >= -TOLS);

   // code to apply on the edge leaving DECIDE: SAR bit resolution or a saturating tracking step
   always_comb begin
      code_nxt = code;
      if (!trk) begin
         if (cnt > tgt) code_nxt[bidx] = 1'b0;
         if (bidx != '0) code_nxt[bidx - 1'b1] = 1'b1;
      end else if (diff < -TOLS) begin
         if (code != CODE_MAX) code_nxt = code + 1'b1;
      end else if (diff > TOLS) begin
         if (code != '0) code_nxt = code - 1'b1;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nstate;
   end

   // next-state logic; an accepted start always restarts the search from SETTLE
   always_comb begin
      nstate = state;
      if (accept) begin
         nstate = S_SETTLE;
      end else begin
         case (state)
            S_IDLE:   nstate = S_IDLE;
            S_SETTLE: if (tmr == SET_LAST) nstate = S_COUNT;
            S_COUNT:  if (tmr == WIN_LAST) nstate = S_DECIDE;
            S_DECIDE: begin
               if (!trk) begin
                  if (bidx != '0)   nstate = S_SETTLE;
                  else if (track_en) nstate = S_TRACK;
                  else               nstate = S_HOLD;
               end else begin
                  nstate = track_en ? S_SETTLE : S_HOLD;
               end
            end
            S_HOLD:   if (track_en) nstate = S_SETTLE;
            S_TRACK:  nstate = track_en ? S_SETTLE : S_HOLD;
            default:  nstate = S_IDLE;
         endcase
      end
   end

   // datapath: timers, tick counter, code, and the registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         code  <= CODE_MSB;
         busy  <= 1'b0;
         done  <= 1'b0;
         lock  <= 1'b0;
         count <= '0;
         bidx  <= BIT_TOP;
         tgt   <= '0;
         cnt   <= '0;
         tmr   <= '0;
         trk   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            tgt  <= target;
            code <= CODE_MSB;
            busy <= 1'b1;
            bidx <= BIT_TOP;
            trk  <= 1'b0;
            lock <= 1'b0;
            tmr  <= '0;
         end else begin
            case (state)
               S_SETTLE: begin
                  if (tmr == SET_LAST) begin
                     tmr <= '0;
                     cnt <= '0;
                  end else begin
                     tmr <= tmr + 32'd1;
                  end
               end
               S_COUNT: begin
                  tmr <= (tmr == WIN_LAST) ? '0 : tmr + 32'd1;
                  if (osc_tick && cnt != CNT_MAX) cnt <= cnt + 1'b1;
               end
               S_DECIDE: begin
                  count <= cnt;
                  lock  <= in_band;
                  code  <= code_nxt;
                  tmr   <= '0;
                  if (!trk) begin
                     if (bidx != '0) begin
                        bidx <= bidx - 1'b1;
                     end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                        trk  <= track_en;
                     end
                  end else if (track_en) begin
                     tgt <= target;
                  end
               end
               S_HOLD: begin
                  if (track_en) begin
                     tgt <= target;
                     trk <= 1'b1;
                     tmr <= '0;
                  end
               end
               S_TRACK: begin
                  tgt <= target;
                  trk <= 1'b1;
                  tmr <= '0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
